mmio_io_ctrl: RTL



---
 rtl/mmio_io_if.sv | 21 ++
 rtl/mmio_io_ctrl.sv | 94 +++++++++
 2 files changed

// File: rtl/mmio_io_if.sv
// CPU memory-bus view of the I/O controller: command, address, write data
// going in; combinational read data and hit flag coming back.
interface mmio_io_if #(
  parameter int DATA_W = 16
);
  logic [6:0]        mem_cmd;
  logic [8:0]        mem_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_hit;

  modport master (
    output mem_cmd, mem_addr, wr_data,
    input  rd_data, rd_hit
  );

  modport slave (
    input  mem_cmd, mem_addr, wr_data,
    output rd_data, rd_hit
  );
endinterface

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O block for the addr[8]=1 region: output port register,
// synchronised input port with sticky change flags, and a prescaled timer.
module mmio_io_ctrl #(
  parameter int         DATA_W    = 16,
  parameter int         OUT_W     = 8,
  parameter int         IN_W      = 8,
  parameter logic [8:0] OUT_ADDR  = 9'h100,
  parameter logic [8:0] IN_ADDR   = 9'h140,
  parameter logic [8:0] EDGE_ADDR = 9'h141,
  parameter logic [8:0] TMR_ADDR  = 9'h180,
  parameter int         PRESCALE  = 50000
) (
  input  logic             clk,
  input  logic             reset,
  mmio_io_if.slave         bus,
  input  logic [IN_W-1:0]  in_pins,
  output logic [OUT_W-1:0] out_pins
);
  localparam logic [6:0] M_READ  = 7'b1100000;
  localparam logic [6:0] M_WRITE = 7'b1110000;
  localparam int         PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic              is_rd, is_wr;
  logic              hit_out, hit_in, hit_edge, hit_tmr;
  logic              edge_rd, edge_rd_p0, tick;
  logic [IN_W-1:0]   sync_p0, sync_p1, sync_p2;
  logic [IN_W-1:0]   flags, edge_set, clr_mask;
  logic [DATA_W-1:0] count;
  logic [PS_W-1:0]   presc;

  assign is_rd    = (bus.mem_cmd == M_READ);
  assign is_wr    = (bus.mem_cmd == M_WRITE);
  assign hit_out  = (bus.mem_addr == OUT_ADDR);
  assign hit_in   = (bus.mem_addr == IN_ADDR);
  assign hit_edge = (bus.mem_addr == EDGE_ADDR);
  assign hit_tmr  = (bus.mem_addr == TMR_ADDR);

  assign edge_rd  = is_rd && hit_edge;
  assign edge_set = sync_p1 ^ sync_p2;
  assign tick     = (presc == PS_W'(PRESCALE - 1));

  // Read-to-clear fires only on the first cycle of a (possibly held) read;
  // new edges are OR-ed in after the clear so they are never lost.
  always_comb begin
    clr_mask = '0;
    if (edge_rd && !edge_rd_p0)
      clr_mask = '1;
    if (is_wr && hit_edge)
      clr_mask = clr_mask | bus.wr_data[IN_W-1:0];
  end

  always_comb begin
    bus.rd_hit  = 1'b0;
    bus.rd_data = '0;
    if (is_rd) begin
      bus.rd_hit = hit_out || hit_in || hit_edge || hit_tmr;
      if (hit_out)  bus.rd_data = DATA_W'(out_pins);
      if (hit_in)   bus.rd_data = DATA_W'(sync_p1);
      if (hit_edge) bus.rd_data = DATA_W'(flags);
      if (hit_tmr)  bus.rd_data = count;
    end
  end

  // p0/p1: two-flop synchroniser; p2: previous stable value for change detect
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      sync_p2    <= '0;
      flags      <= '0;
      edge_rd_p0 <= 1'b0;
      out_pins   <= '0;
      count      <= '0;
      presc      <= '0;
    end else begin
      sync_p0    <= in_pins;
      sync_p1    <= sync_p0;
      sync_p2    <= sync_p1;
      flags      <= (flags & ~clr_mask) | edge_set;
      edge_rd_p0 <= edge_rd;
      if (is_wr && hit_out)
        out_pins <= bus.wr_data[OUT_W-1:0];
      if (is_wr && hit_tmr) begin
        count <= bus.wr_data;
        presc <= '0;
      end else if (tick) begin
        count <= count + 1'b1;
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end
endmodule
